// File: rtl/b16_scan_serializer.sv
// Scan controller for the 16-to-1 mux: loads a word, walks the select through all
// 16 positions and streams the mux output back out over a valid/ready handshake.
module b16_scan_serializer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clock,
    input  logic        reset_,
    input  logic [15:0] d_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] x15_x0,
    output logic [3:0]  b3_b0,
    input  logic        z0,
    output logic        out_bit,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        done,
    output logic [7:0]  word_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] SEL_START = MSB_FIRST ? 4'd15 : 4'd0;
    // 4'd15 is -1 modulo 16, so both scan directions are a single adder
    localparam logic [3:0] SEL_STEP  = MSB_FIRST ? 4'd15 : 4'd1;

    logic [1:0]  state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  word_cnt_q, word_cnt_d;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        sel_d      = sel_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    word_d    = d_in;
                    sel_d     = SEL_START;
                    bit_cnt_d = 4'd0;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (out_ready) begin
                    if (bit_cnt_q == 4'd15) begin
                        state_d    = ST_DONE;
                        word_cnt_d = word_cnt_q + 8'd1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        sel_d     = sel_q + SEL_STEP;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                sel_d   = SEL_START;
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = SEL_START;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q    <= ST_IDLE;
            word_q     <= 16'd0;
            sel_q      <= SEL_START;
            bit_cnt_q  <= 4'd0;
            word_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            sel_q      <= sel_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Handshake flags come from registered state only; z0 is the sole comb input path.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_SCAN);
    assign done      = (state_q == ST_DONE);
    assign x15_x0    = word_q;
    assign b3_b0     = sel_q;
    assign out_bit   = z0;
    assign word_cnt  = word_cnt_q;

endmodule
